// File: rtl/noc_pkg.sv
// Shared NoC definitions: port indices, packet field layout
// and the XY route-direction encoding.
package noc_pkg;

  localparam int PORTS_N = 5;
  localparam int LEFT    = 0;
  localparam int TOP     = 1;
  localparam int RIGHT   = 2;
  localparam int BOT     = 3;
  localparam int RES     = 4;

  typedef logic [2:0] dir_t;

  function automatic int hop_lsb(input int dw);
    return dw;
  endfunction

  function automatic int y_lsb(input int dw, input int hw);
    return dw + hw;
  endfunction

  function automatic int x_lsb(
    input int dw,
    input int hw,
    input int yw
  );
    return dw + hw + yw;
  endfunction

  // X is resolved first, Y only once the column matches
  function automatic dir_t route_dir(
    input logic x_gt,
    input logic x_lt,
    input logic y_gt,
    input logic y_lt
  );
    logic       x_eq;
    logic [4:0] sel;
    x_eq = !x_gt & !x_lt;
    sel  = {x_gt, x_lt,
            x_eq & y_gt,
            x_eq & y_lt,
            x_eq & !y_gt & !y_lt};
    unique case (1'b1)
      sel[4]:  route_dir = 3'(RIGHT);
      sel[3]:  route_dir = 3'(LEFT);
      sel[2]:  route_dir = 3'(BOT);
      sel[1]:  route_dir = 3'(TOP);
      default: route_dir = 3'(RES);
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head is
// presented combinationally on rdata.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic             do_push;
  logic             do_pop;

  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty = wr_q == rd_q;

  assign do_push = push & !full;
  assign do_pop  = pop & !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/xy_switch_buf.sv
// Buffered 5-port XY mesh switch: input FIFOs, per-output RR arbiter.
// XY_SWITCH_HOP_CNT_EN adds a saturating hop field to each packet.
module xy_switch_buf
  import noc_pkg::*;
#(
  parameter int X_CORD     = 0,
  parameter int Y_CORD     = 0,
  parameter int X_W        = 4,
  parameter int Y_W        = 4,
  parameter int DATA_W     = 8,
  parameter int HOP_W      = 4,
  parameter int FIFO_DEPTH = 4,
`ifdef XY_SWITCH_HOP_CNT_EN
  localparam int HW        = HOP_W,
`else
  localparam int HW        = 0 * HOP_W,
`endif
  localparam int PCKT_W    = X_W + Y_W + HW + DATA_W
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [PORTS_N-1:0]          pckt_vld_i,
  input  logic [PORTS_N*PCKT_W-1:0]   pckt_i,
  output logic [PORTS_N-1:0]          pckt_rdy_o,
  output logic [PORTS_N-1:0]          pckt_vld_o,
  output logic [PORTS_N*PCKT_W-1:0]   pckt_o,
  input  logic [PORTS_N-1:0]          pckt_rdy_i,
  output logic                        busy_o
);

  localparam int XL = x_lsb(DATA_W, HW, Y_W);
  localparam int YL = y_lsb(DATA_W, HW);

  localparam logic [X_W-1:0] XC = X_W'(X_CORD);
  localparam logic [Y_W-1:0] YC = Y_W'(Y_CORD);

  logic [PCKT_W-1:0]  head  [PORTS_N];
  dir_t               route [PORTS_N];
  logic [PORTS_N-1:0] gnt   [PORTS_N];
  logic [PORTS_N-1:0] full;
  logic [PORTS_N-1:0] empty;
  logic [PORTS_N-1:0] push;
  logic [PORTS_N-1:0] pop;

  for (genvar i = 0; i < PORTS_N; i++) begin : g_in
    logic [X_W-1:0] hx;
    logic [Y_W-1:0] hy;

    assign push[i] = pckt_vld_i[i] & pckt_rdy_o[i];

    sync_fifo #(
      .WIDTH (PCKT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk_i,
      .rst_ni,
      .push  (push[i]),
      .pop   (pop[i]),
      .wdata (pckt_i[i*PCKT_W +: PCKT_W]),
      .rdata (head[i]),
      .full  (full[i]),
      .empty (empty[i])
    );

    assign hx       = head[i][XL +: X_W];
    assign hy       = head[i][YL +: Y_W];
    assign route[i] = route_dir(hx > XC, hx < XC,
                                hy > YC, hy < YC);
  end

  assign pckt_rdy_o = ~full;

  for (genvar o = 0; o < PORTS_N; o++) begin : g_out
    logic               ld;
    logic [PORTS_N-1:0] req;
    logic               gv;
    logic [2:0]         gidx;
    logic [2:0]         ptr_q;
    logic               vld_q;
    logic [PCKT_W-1:0]  pckt_q;
    logic [PCKT_W-1:0]  sel;
    logic [PCKT_W-1:0]  nxt;

    assign ld = !vld_q | pckt_rdy_i[o];

    always_comb begin
      req = '0;
      for (int i = 0; i < PORTS_N; i++) begin
        req[i] = ld & !empty[i] & (route[i] == 3'(o));
      end
    end

    // search starts just after the last winner
    always_comb begin
      gv   = 1'b0;
      gidx = ptr_q;
      for (int k = 1; k <= PORTS_N; k++) begin
        if (!gv && req[(int'(ptr_q) + k) % PORTS_N]) begin
          gv   = 1'b1;
          gidx = 3'((int'(ptr_q) + k) % PORTS_N);
        end
      end
    end

    assign gnt[o] = gv ? (PORTS_N'(1) << gidx) : '0;

    always_comb begin
      sel = '0;
      for (int i = 0; i < PORTS_N; i++) begin
        if (gidx == 3'(i)) sel = head[i];
      end
    end

`ifdef XY_SWITCH_HOP_CNT_EN
    logic [HW-1:0] hop;
    always_comb begin
      nxt = sel;
      hop = sel[hop_lsb(DATA_W) +: HW];
      if (o != RES && hop != '1) begin
        nxt[hop_lsb(DATA_W) +: HW] = hop + 1'b1;
      end
    end
`else
    assign nxt = sel;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld_q  <= 1'b0;
        pckt_q <= '0;
        ptr_q  <= 3'(RES);
      end else if (gv) begin
        vld_q  <= 1'b1;
        pckt_q <= nxt;
        ptr_q  <= gidx;
      end else if (pckt_rdy_i[o]) begin
        vld_q  <= 1'b0;
      end
    end

    assign pckt_vld_o[o]                = vld_q;
    assign pckt_o[o*PCKT_W +: PCKT_W]   = pckt_q;
  end

  always_comb begin
    pop = '0;
    for (int o = 0; o < PORTS_N; o++) begin
      for (int i = 0; i < PORTS_N; i++) begin
        pop[i] = pop[i] | gnt[o][i];
      end
    end
  end

  assign busy_o = (|(~empty)) | (|pckt_vld_o);

endmodule
